// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB source indices, widths and packet type
package cdb_arbiter_pkg;

   localparam int CDB_NUM_SRC = 3;
   localparam int CDB_DATA_W  = 32;
   localparam int PREG_W      = 6;
   localparam int ROB_W       = 4;

   localparam int CDB_SRC_ALU = 0;
   localparam int CDB_SRC_MUL = 1;
   localparam int CDB_SRC_LSU = 2;

   // Writeback packet as seen by the PRF and the ROB
   typedef struct packed {
      logic [PREG_W-1:0]     preg;
      logic [ROB_W-1:0]      rob;
      logic [CDB_DATA_W-1:0] data;
   } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - functional-unit push ports and CDB broadcast bundle
interface cdb_arbiter_if #(
   parameter int NUM_SRC = 3,
   parameter int DATA_W  = 32,
   parameter int PREG_W  = 6,
   parameter int ROB_W   = 4
);
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_ready;
   logic [NUM_SRC*PREG_W-1:0] src_preg;
   logic [NUM_SRC*ROB_W-1:0]  src_rob;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic                      cdb_ready;
   logic                      cdb_valid;
   logic [1:0]                cdb_src;
   logic [PREG_W-1:0]         cdb_preg;
   logic [ROB_W-1:0]          cdb_rob;
   logic [DATA_W-1:0]         cdb_data;

   // Functional units and CDB consumers side
   modport master (
      output src_valid, src_preg, src_rob, src_data, cdb_ready,
      input  src_ready, cdb_valid, cdb_src, cdb_preg, cdb_rob, cdb_data
   );

   // Arbiter side
   modport slave (
      input  src_valid, src_preg, src_rob, src_data, cdb_ready,
      output src_ready, cdb_valid, cdb_src, cdb_preg, cdb_rob, cdb_data
   );
endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rtl/cdb_arbiter_rr_arbiter.sv - combinational round-robin one-hot grant
module rr_arbiter #(
   parameter  int N  = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   int   idx;
   logic found;

   // Scan from ptr upward modulo N; first requester wins
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < N; off++) begin
         idx = (int'(ptr) + off) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-unit result buffers, round-robin select, registered CDB
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = CDB_NUM_SRC,
   parameter int DATA_W  = CDB_DATA_W,
   parameter int PREG_W  = cdb_arbiter_pkg::PREG_W,
   parameter int ROB_W   = cdb_arbiter_pkg::ROB_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   cdb_arbiter_if.slave   bus
);

   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0] buf_v_q, buf_v_d;
   logic [PREG_W-1:0]  buf_preg_q [NUM_SRC];
   logic [PREG_W-1:0]  buf_preg_d [NUM_SRC];
   logic [ROB_W-1:0]   buf_rob_q  [NUM_SRC];
   logic [ROB_W-1:0]   buf_rob_d  [NUM_SRC];
   logic [DATA_W-1:0]  buf_data_q [NUM_SRC];
   logic [DATA_W-1:0]  buf_data_d [NUM_SRC];

   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               cdb_valid_q, cdb_valid_d;
   logic [1:0]         cdb_src_q, cdb_src_d;
   logic [PREG_W-1:0]  cdb_preg_q, cdb_preg_d;
   logic [ROB_W-1:0]   cdb_rob_q, cdb_rob_d;
   logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;

   logic               out_free;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] grant;
   logic [NUM_SRC-1:0] src_ready;
   logic [NUM_SRC-1:0] push;
   logic [PTR_W-1:0]   grant_idx;
   logic               grant_any;

   // Output register may take a new beat when empty or being consumed
   assign out_free = !cdb_valid_q || bus.cdb_ready;
   assign req      = out_free ? buf_v_q : '0;

   rr_arbiter #(.N(NUM_SRC)) u_rr (
      .req   (req),
      .ptr   (rr_ptr_q),
      .grant (grant)
   );

   // Encode the one-hot grant; buffers accept when empty or draining this cycle
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) grant_idx = PTR_W'(i);
      end
      grant_any = |grant;
      src_ready = flush ? '0 : (~buf_v_q | grant);
      push      = bus.src_valid & src_ready;
   end

   assign bus.src_ready = src_ready;
   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_src   = cdb_src_q;
   assign bus.cdb_preg  = cdb_preg_q;
   assign bus.cdb_rob   = cdb_rob_q;
   assign bus.cdb_data  = cdb_data_q;

   // Holding buffers: drain on grant, refill on push, flush empties all
   always_comb begin
      buf_v_d    = buf_v_q;
      buf_preg_d = buf_preg_q;
      buf_rob_d  = buf_rob_q;
      buf_data_d = buf_data_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) buf_v_d[i] = 1'b0;
         if (push[i]) begin
            buf_v_d[i]    = 1'b1;
            buf_preg_d[i] = bus.src_preg[i*PREG_W +: PREG_W];
            buf_rob_d[i]  = bus.src_rob[i*ROB_W +: ROB_W];
            buf_data_d[i] = bus.src_data[i*DATA_W +: DATA_W];
         end
      end
      if (flush) buf_v_d = '0;
   end

   // CDB output register and round-robin pointer update
   always_comb begin
      cdb_valid_d = cdb_valid_q;
      cdb_src_d   = cdb_src_q;
      cdb_preg_d  = cdb_preg_q;
      cdb_rob_d   = cdb_rob_q;
      cdb_data_d  = cdb_data_q;
      rr_ptr_d    = rr_ptr_q;
      if (flush) begin
         cdb_valid_d = 1'b0;
      end else if (grant_any) begin
         cdb_valid_d = 1'b1;
         cdb_src_d   = 2'(grant_idx);
         cdb_preg_d  = buf_preg_q[grant_idx];
         cdb_rob_d   = buf_rob_q[grant_idx];
         cdb_data_d  = buf_data_q[grant_idx];
         rr_ptr_d    = (grant_idx == PTR_W'(NUM_SRC-1)) ? '0 : grant_idx + 1'b1;
      end else if (out_free) begin
         cdb_valid_d = 1'b0;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_v_q     <= '0;
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_src_q   <= '0;
         cdb_preg_q  <= '0;
         cdb_rob_q   <= '0;
         cdb_data_q  <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            buf_preg_q[i] <= '0;
            buf_rob_q[i]  <= '0;
            buf_data_q[i] <= '0;
         end
      end else begin
         buf_v_q     <= buf_v_d;
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_src_q   <= cdb_src_d;
         cdb_preg_q  <= cdb_preg_d;
         cdb_rob_q   <= cdb_rob_d;
         cdb_data_q  <= cdb_data_d;
         buf_preg_q  <= buf_preg_d;
         buf_rob_q   <= buf_rob_d;
         buf_data_q  <= buf_data_d;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed vector bench for cdb_arbiter
module tb_cdb_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;

   int n_vec = 0;
   int n_bad = 0;

   cdb_arbiter_if bus ();

   cdb_arbiter dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Source i drives {preg+i, rob+i, data+i} of the vector payload
   typedef struct {
      logic        fl;
      logic [2:0]  sv;
      logic        rdy;
      logic [5:0]  preg;
      logic [3:0]  rob;
      logic [31:0] data;
      logic [2:0]  e_ready;
      logic        e_v;
      logic [1:0]  e_src;
      logic [5:0]  e_preg;
      logic [3:0]  e_rob;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic fl, logic [2:0] sv, logic rdy, logic [5:0] preg,
                               logic [3:0] rob, logic [31:0] data, logic [2:0] e_ready,
                               logic e_v, logic [1:0] e_src, logic [5:0] e_preg,
                               logic [3:0] e_rob, logic [31:0] e_data);
      vec_t v;
      v.fl = fl; v.sv = sv; v.rdy = rdy; v.preg = preg; v.rob = rob; v.data = data;
      v.e_ready = e_ready; v.e_v = e_v; v.e_src = e_src;
      v.e_preg = e_preg; v.e_rob = e_rob; v.e_data = e_data;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic [2:0] sv, input logic rdy,
                        input logic [5:0] preg, input logic [3:0] rob, input logic [31:0] data);
      flush         = fl;
      bus.src_valid = sv;
      bus.cdb_ready = rdy;
      for (int i = 0; i < 3; i++) begin
         bus.src_preg[i*6 +: 6]   = preg + 6'(i);
         bus.src_rob[i*4 +: 4]    = rob + 4'(i);
         bus.src_data[i*32 +: 32] = data + 32'(i);
      end
   endtask

   task automatic chk_beat(input string name, input int idx, input logic [1:0] src,
                           input logic [5:0] preg, input logic [3:0] rob, input logic [31:0] data);
      n_vec++;
      chk({name, "_valid"}, idx, 32'(bus.cdb_valid), 32'd1);
      chk({name, "_src"},   idx, 32'(bus.cdb_src),   32'(src));
      chk({name, "_preg"},  idx, 32'(bus.cdb_preg),  32'(preg));
      chk({name, "_rob"},   idx, 32'(bus.cdb_rob),   32'(rob));
      chk({name, "_data"},  idx, bus.cdb_data,       data);
   endtask

   initial begin
      drive(1'b0, 3'b000, 1'b1, 6'd0, 4'd0, 32'd0);

      //          fl sv     rdy preg rob data          e_rdy  v src eprg erob edata
      // idle after reset
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 0, 0, 0,  0,  32'h0));
      // contention, rr_ptr=0: beats 0,1,2
      vecs.push_back(mk(0, 3'b111, 1, 10, 4, 32'h100,   3'b111, 0, 0, 0,  0,  32'h0));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b001, 1, 0, 10, 4,  32'h100));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b011, 1, 1, 11, 5,  32'h101));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 1, 2, 12, 6,  32'h102));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 0, 0, 0,  0,  32'h0));
      // single ALU push p7 rob2 0xF
      vecs.push_back(mk(0, 3'b001, 1, 7,  2, 32'hF,     3'b111, 0, 0, 0,  0,  32'h0));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 1, 0, 7,  2,  32'hF));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 0, 0, 0,  0,  32'h0));
      // fairness: MUL streaming, ALU pushes once (rr_ptr=1)
      vecs.push_back(mk(0, 3'b011, 1, 20, 8, 32'h200,   3'b111, 0, 0, 0,  0,  32'h0));
      vecs.push_back(mk(0, 3'b010, 1, 30, 1, 32'h300,   3'b110, 1, 1, 21, 9,  32'h201));
      vecs.push_back(mk(0, 3'b010, 1, 40, 3, 32'h400,   3'b101, 1, 0, 20, 8,  32'h200));
      vecs.push_back(mk(0, 3'b010, 1, 40, 3, 32'h400,   3'b111, 1, 1, 31, 2,  32'h301));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 1, 1, 41, 4,  32'h401));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 0, 0, 0,  0,  32'h0));
      // backpressure: beat p9 rob5 0x300 held for 4 stalled cycles
      vecs.push_back(mk(0, 3'b100, 1, 7,  3, 32'h2FE,   3'b111, 0, 0, 0,  0,  32'h0));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 1, 2, 9,  5,  32'h300));
      vecs.push_back(mk(0, 3'b100, 0, 50, 10, 32'h500,  3'b111, 1, 2, 9,  5,  32'h300));
      vecs.push_back(mk(0, 3'b000, 0, 0,  0, 32'h0,     3'b011, 1, 2, 9,  5,  32'h300));
      vecs.push_back(mk(0, 3'b000, 0, 0,  0, 32'h0,     3'b011, 1, 2, 9,  5,  32'h300));
      vecs.push_back(mk(0, 3'b000, 0, 0,  0, 32'h0,     3'b011, 1, 2, 9,  5,  32'h300));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 1, 2, 52, 12, 32'h502));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 0, 0, 0,  0,  32'h0));
      // flush with ALU and LSU buffered; flush-cycle pushes dropped
      vecs.push_back(mk(0, 3'b101, 1, 1,  1, 32'h10,    3'b111, 0, 0, 0,  0,  32'h0));
      vecs.push_back(mk(1, 3'b111, 1, 5,  5, 32'h50,    3'b000, 0, 0, 0,  0,  32'h0));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 0, 0, 0,  0,  32'h0));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 0, 0, 0,  0,  32'h0));
      // tag p0 passes through unchanged (MUL payload wraps to zero)
      vecs.push_back(mk(0, 3'b010, 1, 63, 15, 32'hFFFF_FFFF, 3'b111, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 3'b000, 1, 0,  0, 32'h0,     3'b111, 1, 1, 0,  0,  32'h0));

      // reset state
      #2;
      n_vec++;
      chk("rst_valid", -1, 32'(bus.cdb_valid), 32'd0);
      chk("rst_src",   -1, 32'(bus.cdb_src),   32'd0);
      chk("rst_preg",  -1, 32'(bus.cdb_preg),  32'd0);
      chk("rst_rob",   -1, 32'(bus.cdb_rob),   32'd0);
      chk("rst_data",  -1, bus.cdb_data,       32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[k]) begin
         vec_t v;
         v = vecs[k];
         @(negedge clk);
         drive(v.fl, v.sv, v.rdy, v.preg, v.rob, v.data);
         #1;
         chk("src_ready", k, 32'(bus.src_ready), 32'(v.e_ready));
         @(posedge clk);
         #1;
         n_vec++;
         chk("cdb_valid", k, 32'(bus.cdb_valid), 32'(v.e_v));
         if (v.e_v) begin
            chk("cdb_src",  k, 32'(bus.cdb_src),  32'(v.e_src));
            chk("cdb_preg", k, 32'(bus.cdb_preg), 32'(v.e_preg));
            chk("cdb_rob",  k, 32'(bus.cdb_rob),  32'(v.e_rob));
            chk("cdb_data", k, bus.cdb_data,      v.e_data);
         end
      end

      // async reset mid-stream: ALU beat on bus (rr_ptr=1), LSU buffered
      @(negedge clk);
      drive(1'b0, 3'b001, 1'b1, 6'd33, 4'd7, 32'h700);
      @(negedge clk);
      drive(1'b0, 3'b100, 1'b1, 6'd33, 4'd7, 32'h700);
      @(posedge clk);
      #1;
      chk_beat("pre_rst", 100, 2'd0, 6'd33, 4'd7, 32'h700);
      #1;
      rst = 1'b1;
      #1;
      n_vec++;
      chk("arst_valid", 101, 32'(bus.cdb_valid), 32'd0);
      chk("arst_preg",  101, 32'(bus.cdb_preg),  32'd0);
      chk("arst_data",  101, bus.cdb_data,       32'd0);
      @(negedge clk);
      drive(1'b0, 3'b000, 1'b1, 6'd0, 4'd0, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 3'b101, 1'b1, 6'd40, 4'd1, 32'h40);
      @(posedge clk);
      #1;
      n_vec++;
      chk("post_rst_idle", 102, 32'(bus.cdb_valid), 32'd0);
      @(negedge clk);
      drive(1'b0, 3'b000, 1'b1, 6'd0, 4'd0, 32'h0);
      @(posedge clk);
      #1;
      chk_beat("post_rst_first", 103, 2'd0, 6'd40, 4'd1, 32'h40);
      @(posedge clk);
      #1;
      chk_beat("post_rst_second", 104, 2'd2, 6'd42, 4'd3, 32'h42);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) writeback port among the core's functional units: ALU, MUL and LSU.
- Each unit pushes a completed result into a one-entry holding buffer in this block.
- A round-robin arbiter selects one buffered result per cycle into a registered CDB output.
- The CDB output is broadcast to the physical register file, the ready bits, the reservation stations and the ROB done-marking logic.

Parameters:
- NUM_SRC, 3, number of requesting functional units (index 0=ALU, 1=MUL, 2=LSU).
- DATA_W, 32, result width.
- PREG_W, 6, physical register tag width.
- ROB_W, 4, ROB index width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  pipeline flush (mispredict/exception); discard all pending results.
- src_valid  in  NUM_SRC  per-source result valid.
- src_ready  out  NUM_SRC  per-source buffer can accept.
- src_preg  in  NUM_SRC*PREG_W  per-source destination physical register.
- src_rob  in  NUM_SRC*ROB_W  per-source ROB index.
- src_data  in  NUM_SRC*DATA_W  per-source result value.
- cdb_ready  in  1  consumer accepts the CDB beat (ROB/PRF backpressure).
- cdb_valid  out  1  CDB beat valid.
- cdb_src  out  2  index of the winning source.
- cdb_preg  out  PREG_W  broadcast tag.
- cdb_rob  out  ROB_W  broadcast ROB index.
- cdb_data  out  DATA_W  broadcast value.

Behaviour:
Reset:
- All buffers are empty.
- cdb_valid=0; cdb_src, cdb_preg, cdb_rob and cdb_data are 0.
- rr_ptr=0.
- src_ready is all-ones one cycle after rst deasserts. It is combinationally all-ones while reset is low and flush is low.

Push:
- A source i transfers on a rising edge when src_valid[i] and src_ready[i] are both high.
- The buffer captures preg/rob/data.
- src_ready[i] = !flush && (!buf_v[i] || grant[i]), which allows a same-cycle drain and refill.

Output register:
- The output register can load when out_free = !cdb_valid || cdb_ready.

Arbitration (combinational, on buffered entries only):
- Arbitration runs only when out_free is high.
- Starting at rr_ptr, the first i in increasing modulo order with buf_v[i] set wins. grant is one-hot or zero.
- On a grant to k: the output register loads buffer k, cdb_valid<=1, cdb_src<=k, and rr_ptr<=(k+1) mod NUM_SRC.
- If no buffer is valid and out_free is high: cdb_valid<=0 and rr_ptr is unchanged.
- If out_free is low: no grant, and the output register and rr_ptr hold.

Latency:
- A push at edge t can reach the CDB at edge t+1 at the earliest. cdb_valid is then visible in the cycle after edge t+1 (2-cycle minimum from src_valid).
- With continuous cdb_ready, each source wins at least once per NUM_SRC cycles.

Flush:
- Flush has priority over everything else.
- On the edge with flush high: all buf_v<=0, cdb_valid<=0, and rr_ptr is unchanged.
- Pushes in the flush cycle are dropped, because src_ready=0 while flush is high.

Other rules:
- Data is held stable on the CDB while cdb_valid && !cdb_ready.
- Asserting reset mid-transfer clears state immediately (asynchronous). No partial beats are emitted.
- Tag value 0 (p0) is passed through unchanged. Suppressing x0 writes is the register file's job.

Decomposition:
- general_defines holds CDB_SRC_ALU/MUL/LSU index constants, PREG_W and ROB_W.
- general_defines also holds a packed cdb_pkt_t struct {preg, rob, data} that is shared with the PRF and the ROB.
- Sub-module rr_arbiter (parameter N) takes a request vector and pointer and returns a one-hot grant. It is combinational and reused by the issue select logic.

Test Plan:
- Single push: ALU pushes preg=7, rob=2, data=0x0000000F at edge 1 → cdb_valid=1 after edge 2 with cdb_src=0, preg=7, rob=2, data=0x0F. cdb_valid=0 after edge 3.
- Contention: ALU, MUL and LSU all push in the same cycle with rr_ptr=0 → CDB beats are src 0, 1, 2 on three consecutive cycles, and rr_ptr ends at 0.
- Fairness: MUL is held valid continuously with new data each cycle and ALU pushes once → the ALU beat appears within 2 CDB cycles, and MUL is not starved.
- Backpressure: hold cdb_ready=0 for 4 cycles with beat {p9, rob5, 0x300} on the bus → outputs stay stable and src_ready for a refilled buffer is 0. After cdb_ready=1, the next beat follows on the next edge.
- Flush: buffer ALU and LSU results, then assert flush for 1 cycle → cdb_valid=0, all buffers are empty, and no beat is emitted. src_ready=0 during the flush cycle and returns to all-ones after it.
- Async reset mid-stream: assert rst between edges while cdb_valid=1 → cdb_valid drops immediately and rr_ptr=0. The first beat after release comes from the lowest-index pushing source.
